// File: rtl/pc_fetch_unit.sv
// ----------------------------------------------------------------------------
// pc_fetch_unit
//   Holds the program counter and fetches one instruction per pass from
//   instruction memory over a req/ack handshake. The fetched word is presented
//   to control_unit during EXEC. On the EXEC cycle without stall, the
//   pc_control decision returned by control_unit forms the next PC.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   imem_req     fetch request (high only in FETCH)
//   imem_addr    fetch address (always equals pc)
//   imem_rdata   instruction word, valid with imem_ack
//   imem_ack     memory returns imem_rdata this cycle
//   instruction  registered instruction to control_unit
//   instr_valid  high while in EXEC
//   pc           current program counter
//   pc_plus4     pc + 4, wraps modulo 2^32
//   pc_control   0001 jump, 0010 jump register, 0011 branch taken, else seq
//   rs_data      jump-register target
//   stall        holds EXEC; pc does not advance
//   fetch_err    sticky: fetch timed out waiting for imem_ack
//   align_err    sticky: a misaligned next-PC target was seen
// ----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic [3:0]  pc_control,
    input  logic [31:0] rs_data,
    input  logic        stall,
    output logic        fetch_err,
    output logic        align_err
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RETRY = 2'd2,
        EXEC  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      next_pc;
    logic [31:0]      next_pc_aligned;
    logic             next_pc_misaligned;

    // Next-PC selection; all arithmetic wraps silently modulo 2^32.
    function automatic logic [31:0] calc_next_pc(
        input logic [3:0]  ctl,
        input logic [31:0] pc4,
        input logic [31:0] instr,
        input logic [31:0] rs
    );
        case (ctl)
            4'b0001: calc_next_pc = {pc4[31:28], instr[25:0], 2'b00};
            4'b0010: calc_next_pc = rs;
            4'b0011: calc_next_pc = pc4 + {{14{instr[15]}}, instr[15:0], 2'b00};
            default: calc_next_pc = pc4;
        endcase
    endfunction

    // A misaligned target is forced down to the enclosing word.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        word_align = {addr[31:2], 2'b00};
    endfunction

    assign pc_plus4           = pc + 32'd4;
    assign next_pc            = calc_next_pc(pc_control, pc_plus4, instruction, rs_data);
    assign next_pc_aligned    = word_align(next_pc);
    assign next_pc_misaligned = |next_pc[1:0];

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == EXEC);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = FETCH;
            FETCH: begin
                if (imem_ack)
                    state_nxt = EXEC;
                else if (wait_cnt == CNT_LAST)
                    state_nxt = RETRY;
            end
            RETRY: state_nxt = FETCH;
            EXEC:  begin
                if (!stall)
                    state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instruction <= 32'h0000_0000;
            wait_cnt    <= '0;
            fetch_err   <= 1'b0;
            align_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                FETCH: begin
                    if (imem_ack) begin
                        instruction <= imem_rdata;
                        wait_cnt    <= '0;
                    end else if (wait_cnt == CNT_LAST) begin
                        fetch_err <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                EXEC: begin
                    // pc_control and rs_data matter only on this edge.
                    if (!stall) begin
                        pc <= next_pc_aligned;
                        if (next_pc_misaligned)
                            align_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
